wm8731_config_seq: RTL and testbench

Power-up configuration sequencer for the WM8731 codec. It walks a fixed 11-entry register table and issues one 24-bit I2C write word per entry to the downstream I2C controller (`i2cc`) through that controller's `din`/`wr_i2c`/`i2c_idle` handshake. It sits directly upstream of `i2cc` and reports completion or a handshake timeout to the top level.

---
 rtl/wm8731_config_seq.sv | 133 +++++++++++++
 tb/tb_wm8731_config_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_config_seq.sv
// Power-up configuration sequencer for the WM8731 codec: walks an 11-entry
// register table and issues one 24-bit write word per entry to the I2C controller.
module wm8731_config_seq #(
  parameter logic [7:0]  DEV_ADDR     = 8'h34,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_idle,
  output logic [23:0] i2c_data,
  output logic        wr_i2c,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  idx
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [3:0]       LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Register table as constant logic; it is a ROM and needs no reset.
  function automatic logic [23:0] word_at(input logic [3:0] i);
    logic [6:0] r;
    logic [8:0] v;
    // NOTE: every path assigns r and v first, so the decode cannot hold state.
    r = 7'h00;
    v = 9'h000;
    case (i)
      4'd0:    begin r = 7'h0F; v = 9'h000; end
      4'd1:    begin r = 7'h00; v = 9'h017; end
      4'd2:    begin r = 7'h01; v = 9'h017; end
      4'd3:    begin r = 7'h02; v = 9'h079; end
      4'd4:    begin r = 7'h03; v = 9'h079; end
      4'd5:    begin r = 7'h04; v = 9'h012; end
      4'd6:    begin r = 7'h05; v = 9'h000; end
      4'd7:    begin r = 7'h06; v = 9'h000; end
      4'd8:    begin r = 7'h07; v = 9'h042; end
      4'd9:    begin r = 7'h08; v = 9'h000; end
      4'd10:   begin r = 7'h09; v = 9'h001; end
      default: begin r = 7'h00; v = 9'h000; end
    endcase
    return {DEV_ADDR, r, v};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      i2c_data <= '0;
      wr_i2c   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      idx      <= '0;
    end else begin
      // NOTE: non-blocking default makes wr_i2c a one-clock pulse unless re-asserted below.
      wr_i2c <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            idx      <= '0;
            i2c_data <= word_at(4'd0);
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (i2c_idle) begin
            wr_i2c <= 1'b1;
            cnt    <= '0;
            state  <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // A controller that never leaves idle has dropped the request.
          if (!i2c_idle) begin
            state <= S_WAIT_IDLE;
          end else if (cnt == TIMEOUT) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (i2c_idle) begin
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx      <= idx + 1'b1;
              i2c_data <= word_at(idx + 1'b1);
              state    <= S_CHECK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_config_seq.sv
// Bench for wm8731_config_seq: behavioural I2C controller responder with random
// bus times, table-derived expected words, and timing/corner-case sequences.
module tb_wm8731_config_seq;

  localparam int          GAP = 16;
  localparam int          TMO = 64;
  localparam logic [7:0]  DEV = 8'h34;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        i2c_idle;
  logic [23:0] i2c_data;
  logic        wr_i2c;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  idx;

  wm8731_config_seq #(
    .DEV_ADDR    (DEV),
    .GAP_CYCLES  (GAP),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .i2c_idle(i2c_idle),
    .i2c_data(i2c_data),
    .wr_i2c  (wr_i2c),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .idx     (idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected table: entry index (also the expected idx output), register, value.
  typedef struct {
    logic [3:0] index;
    logic [6:0] r;
    logic [8:0] v;
  } entry_t;
  entry_t tbl[11];

  function automatic logic [23:0] model_word(input int i);
    return {DEV, tbl[i].r, tbl[i].v};
  endfunction

  // Behavioural I2C controller: idle falls one clock after a strobe, rises later.
  logic        resp_idle = 1'b1;
  logic        force_low = 1'b0;
  bit          resp_stuck = 1'b0;
  int          busy_lo = 100;
  int          busy_hi = 100;
  logic [23:0] got_word[$];
  logic [3:0]  got_idx[$];
  logic [23:0] cap_word;
  int          strobe_cyc = 0;
  int          first_strobe_cyc = 0;
  int          rise_cyc = 0;
  int          data_unstable = 0;
  int          long_strobe = 0;
  logic        prev_wr = 1'b0;

  assign i2c_idle = resp_idle & ~force_low;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_i2c === 1'b1) begin
        if (got_word.size() == 0) first_strobe_cyc = cyc;
        got_word.push_back(i2c_data);
        got_idx.push_back(idx);
        strobe_cyc = cyc;
        cap_word   = i2c_data;
        if (!resp_stuck) begin
          @(negedge clk);
          if (i2c_data !== cap_word) data_unstable++;
          resp_idle = 1'b0;
          repeat (int'($urandom_range(busy_hi, busy_lo))) @(negedge clk);
          resp_idle = 1'b1;
          rise_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_i2c === 1'b1 && prev_wr === 1'b1) long_strobe++;
      prev_wr = wr_i2c;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    got_word.delete();
    got_idx.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("flags_clear_after_start", {done, error}, 2'b00);
  endtask

  task automatic wait_end(input int budget, output int end_cyc);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    end_cyc = cyc;
    check("end_within_budget", done || error, 1'b1);
  endtask

  task automatic wait_count(input int n, input int budget);
    int k = 0;
    while (got_word.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("reach_strobe_%0d", n), got_word.size() >= n, 1'b1);
  endtask

  task automatic check_full(input string tag, input int end_cyc);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_idx"}, idx, 4'd10);
    check({tag, "_count"}, got_word.size(), 11);
    check({tag, "_done_latency"}, end_cyc - rise_cyc, GAP + 1);
    for (int i = 0; i < 11 && i < got_word.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), got_word[i], model_word(i));
      check($sformatf("%s_idx%0d", tag, i), got_idx[i], tbl[i].index);
    end
  endtask

  initial begin
    int t_end;
    int rel;
    int busy_cyc;

    tbl[0]  = '{4'd0,  7'h0F, 9'h000};
    tbl[1]  = '{4'd1,  7'h00, 9'h017};
    tbl[2]  = '{4'd2,  7'h01, 9'h017};
    tbl[3]  = '{4'd3,  7'h02, 9'h079};
    tbl[4]  = '{4'd4,  7'h03, 9'h079};
    tbl[5]  = '{4'd5,  7'h04, 9'h012};
    tbl[6]  = '{4'd6,  7'h05, 9'h000};
    tbl[7]  = '{4'd7,  7'h06, 9'h000};
    tbl[8]  = '{4'd8,  7'h07, 9'h042};
    tbl[9]  = '{4'd9,  7'h08, 9'h000};
    tbl[10] = '{4'd10, 7'h09, 9'h001};

    // Reset held with start high: everything stays zero.
    reset = 1'b1;
    start = 1'b0;
    #1 reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {i2c_data, wr_i2c, busy, done, error, idx}, '0);
    reset = 1'b1;
    @(negedge clk);
    busy_cyc = cyc;
    start = 1'b0;
    check("busy_one_edge_after_start", busy, 1'b1);
    check("first_word_loaded", i2c_data, model_word(0));
    check("first_idx", idx, 4'd0);
    wait_count(1, 10);
    check("strobe_latency", first_strobe_cyc - busy_cyc, 1);
    wait_end(20000, t_end);
    check_full("full", t_end);
    if (got_word.size() == 11) begin
      check("anchor_idx0", got_word[0], 24'h341E00);
      check("anchor_idx8", got_word[8], 24'h340E42);
      check("anchor_idx10", got_word[10], 24'h341201);
    end

    // Random bus times.
    busy_lo = 2;
    busy_hi = 40;
    for (int r = 0; r < 3; r++) begin
      clear_log();
      do_start();
      wait_end(20000, t_end);
      check_full($sformatf("rand%0d", r), t_end);
    end

    // Controller never leaves idle: timeout on entry 0.
    resp_stuck = 1'b1;
    clear_log();
    do_start();
    wait_end(500, t_end);
    check("stuck_error", error, 1'b1);
    check("stuck_done", done, 1'b0);
    check("stuck_busy", busy, 1'b0);
    check("stuck_idx", idx, 4'd0);
    check("stuck_latency", t_end - strobe_cyc, TMO + 1);
    repeat (50) @(negedge clk);
    check("stuck_single_strobe", got_word.size(), 1);
    check("stuck_error_sticky", error, 1'b1);
    resp_stuck = 1'b0;
    clear_log();
    do_start();
    wait_end(20000, t_end);
    check_full("after_error", t_end);

    // Controller busy at sequence start: no strobe until it goes idle.
    busy_lo = 100;
    busy_hi = 100;
    force_low = 1'b1;
    clear_log();
    do_start();
    repeat (50) @(negedge clk);
    check("held_low_no_strobe", got_word.size(), 0);
    check("held_low_busy", busy, 1'b1);
    force_low = 1'b0;
    rel = cyc;
    wait_count(1, 5);
    check("held_low_release_latency", first_strobe_cyc - rel, 1);
    wait_end(20000, t_end);
    check_full("held_low", t_end);

    // start during entry 4 is ignored.
    busy_lo = 2;
    busy_hi = 40;
    clear_log();
    do_start();
    wait_count(5, 2000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midstart_idx", idx, 4'd4);
    check("midstart_busy", busy, 1'b1);
    wait_end(20000, t_end);
    check_full("midstart", t_end);

    // Asynchronous reset during WAIT_IDLE of entry 6.
    busy_lo = 100;
    busy_hi = 100;
    clear_log();
    do_start();
    wait_count(7, 4000);
    repeat (10) @(negedge clk);
    check("pre_reset_idx", idx, 4'd6);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {i2c_data, wr_i2c, busy, done, error, idx}, '0);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    do_start();
    wait_end(20000, t_end);
    check_full("after_reset", t_end);
    if (got_word.size() > 0) check("after_reset_first_word", got_word[0], 24'h341E00);

    check("data_stable_through_handshake", data_unstable, 0);
    check("strobe_one_cycle", long_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
